// File: rtl/snax_simbacore_cfgseq_pkg.sv
// -----------------------------------------------------------------------------
// snax_simbacore_cfgseq_pkg
// Shared types and constants for the SimbaCore CSR configuration sequencer:
//   - sequencer FSM state encoding
//   - indices of the read-only status words returned to the CSR manager
//   - location of the timeout word and the clear-statistics flag in the RW set
// -----------------------------------------------------------------------------
package snax_simbacore_cfgseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Read-only status word indices
    localparam int unsigned RO_BUSY   = 0;
    localparam int unsigned RO_CYCLES = 1;
    localparam int unsigned RO_JOBS   = 2;
    localparam int unsigned RO_STATUS = 3;

    // RW config layout
    localparam int unsigned CLEAR_STATS_BIT = 31;
    localparam int unsigned TIMEOUT_IDX     = 0;

endpackage

// File: rtl/snax_simbacore_csr_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// snax_simbacore_csr_cfg_sequencer
// Accelerator-side endpoint of the SimbaCore CSR register-set handshake.
// Accepts one packed RW config set at a time, holds it as the active job
// configuration, launches the job, counts its cycles with a timeout watchdog
// and reports busy / last cycle count / job count / abort status.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   csr_reg_rw_set_i       RW config set from CSR manager (word 0 = timeout,
//                          last word bit 31 = clear statistics)
//   csr_reg_set_valid_i    config set valid
//   csr_reg_set_ready_o    high in IDLE only; set consumed on valid && ready
//   csr_reg_ro_set_o       status: [0] busy, [1] cycles, [2] jobs,
//                          [3] {abort count[15:0], 15'b0, sticky error}
//   acc_cfg_o              latched active config
//   acc_start_o            one-cycle job start pulse
//   acc_done_i             one-cycle job completion pulse (RUN only)
//   acc_abort_o            one-cycle abort pulse on timeout
// -----------------------------------------------------------------------------
module snax_simbacore_csr_cfg_sequencer
    import snax_simbacore_cfgseq_pkg::*;
#(
    parameter int unsigned NumRwCsr = 7,
    parameter int unsigned NumRoCsr = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumRwCsr-1:0][31:0]  csr_reg_rw_set_i,
    input  logic                       csr_reg_set_valid_i,
    output logic                       csr_reg_set_ready_o,
    output logic [NumRoCsr-1:0][31:0]  csr_reg_ro_set_o,
    output logic [NumRwCsr-1:0][31:0]  acc_cfg_o,
    output logic                       acc_start_o,
    input  logic                       acc_done_i,
    output logic                       acc_abort_o
);

    state_e                     r_state;
    state_e                     w_state_next;
    logic [NumRwCsr-1:0][31:0]  r_cfg;
    logic [31:0]                r_cnt;
    logic [31:0]                r_cycles;
    logic [31:0]                r_jobs;
    logic                       r_err;
    logic [15:0]                r_aborts;

    logic [31:0]                w_cnt_inc;
    logic                       w_accept;
    logic                       w_clear;
    logic                       w_done;
    logic                       w_timeout;

    // w_cnt_inc is the count "as seen" in the current RUN cycle: the register
    // is zeroed in START, so the first RUN cycle observes 1.
    always_comb begin
        w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
        w_accept  = (r_state == IDLE) && csr_reg_set_valid_i;
        w_clear   = csr_reg_rw_set_i[NumRwCsr-1][CLEAR_STATS_BIT];
        w_done    = (r_state == RUN) && acc_done_i;
        // Done takes priority over a coincident timeout.
        w_timeout = (r_state == RUN) && !acc_done_i &&
                    (r_cfg[TIMEOUT_IDX] != '0) &&
                    (w_cnt_inc == r_cfg[TIMEOUT_IDX]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        csr_reg_set_ready_o = 1'b0;
        acc_start_o         = 1'b0;
        acc_abort_o         = 1'b0;
        case (r_state)
            IDLE: begin
                csr_reg_set_ready_o = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                end
            end
            START: begin
                acc_start_o  = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    acc_abort_o  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg    <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
            r_jobs   <= '0;
            r_err    <= 1'b0;
            r_aborts <= '0;
        end else begin
            if (w_accept) begin
                r_cfg <= csr_reg_rw_set_i;
                if (w_clear) begin
                    r_jobs   <= '0;
                    r_err    <= 1'b0;
                    r_aborts <= '0;
                end
            end

            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_done) begin
                r_cycles <= w_cnt_inc;
                r_jobs   <= r_jobs + 32'd1;
            end else if (w_timeout) begin
                r_cycles <= w_cnt_inc;
                r_err    <= 1'b1;
                if (r_aborts != '1) begin
                    r_aborts <= r_aborts + 16'd1;
                end
            end
        end
    end

    always_comb begin
        csr_reg_ro_set_o               = '0;
        csr_reg_ro_set_o[RO_BUSY][0]   = (r_state != IDLE);
        csr_reg_ro_set_o[RO_CYCLES]    = r_cycles;
        csr_reg_ro_set_o[RO_JOBS]      = r_jobs;
        csr_reg_ro_set_o[RO_STATUS]    = {r_aborts, 15'b0, r_err};
    end

    assign acc_cfg_o = r_cfg;

endmodule

// File: doc/snax_simbacore_csr_cfg_sequencer.md
# snax_simbacore_csr_cfg_sequencer

Accelerator-side endpoint of the SimbaCore CSR register-set handshake. Consumes the packed read-write CSR set (valid/ready) produced by the CSR manager, latches it as the active job configuration, and launches and tracks one accelerator job at a time with a timeout watchdog. Returns busy, cycle-count and job statistics as the packed read-only CSR set.

## Interface
- NumRwCsr, 7, number of 32-bit RW config words (≥2); word 0 = timeout, word NumRwCsr-1 bit 31 = clear-stats
- NumRoCsr, 4, number of 32-bit RO status words (fixed at 4)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_reg_rw_set_i  in  [NumRwCsr-1:0][31:0]  config set from CSR manager
- csr_reg_set_valid_i  in  1  config set valid
- csr_reg_set_ready_o  out  1  config set accepted when valid && ready
- csr_reg_ro_set_o  out  [NumRoCsr-1:0][31:0]  status back to CSR manager
- acc_cfg_o  out  [NumRwCsr-1:0][31:0]  latched active config, stable from start to end of job
- acc_start_o  out  1  single-cycle job start pulse
- acc_done_i  in  1  single-cycle job completion pulse from datapath
- acc_abort_o  out  1  single-cycle abort pulse on timeout

## Operation
- States: IDLE, START, RUN.
- IDLE: ready=1. On valid&&ready: latch all words into acc_cfg_o, go START. If word NumRwCsr-1 bit 31 set: clear RO[2] and RO[3] in the same edge; job still launches.
- START: ready=0, acc_start_o=1 for exactly this cycle, cycle counter := 0, go RUN.
- RUN: ready=0; counter increments each cycle (first RUN cycle reads 1, saturates at 2^32-1).
  - acc_done_i=1: RO[1] := counter, RO[2] += 1 (wraps mod 2^32), go IDLE.
  - Else if timeout word ≠ 0 and counter == timeout: acc_abort_o=1, RO[1] := counter, RO[3] bit 0 := 1 (sticky), RO[3][31:16] += 1 (saturating at 0xFFFF), go IDLE.
  - done and timeout in same cycle: done wins, no abort, no error.
  - timeout == 0: watchdog disabled.
- acc_done_i outside RUN is ignored (no counter update).
- RO[0] = {31'b0, busy}, busy = (state ≠ IDLE). RO[3][15:1] = 0.
- Config words are not interpreted beyond word 0 and the clear-stats bit; all words pass to acc_cfg_o unchanged.

## Timing
- Reset (async assert, sync release): state IDLE, ready=1, acc_cfg_o=0, acc_start_o=0, acc_abort_o=0, all RO words 0.
- Accept edge → acc_start_o high in next cycle → RUN the cycle after.
- Minimum job: accept at cycle 0, start at 1, done at 2 → RO[1]=1, ready high in cycle 3; next accept possible in cycle 3.
- RO outputs registered; update visible the cycle after the done/abort edge.
- ready depends only on state (no combinational path from valid).
- valid held while busy: ready low, set not consumed, no effect.
- Reset mid-job: return to IDLE immediately, no abort pulse, statistics lost.

## Structure
- Package snax_simbacore_cfgseq_pkg: state enum (IDLE/START/RUN), RO index constants (RO_BUSY=0, RO_CYCLES=1, RO_JOBS=2, RO_STATUS=3), CLEAR_STATS_BIT=31, TIMEOUT_IDX=0.
- Single module; counters and FSM inline, no sub-module.

## Test plan
- Reset: rst_ni low mid-RUN → all outputs 0, ready=1, RO all 0, no abort pulse.
- Basic job: timeout=0, accept, done 5 cycles after start → acc_start_o one pulse, RO[1]=5, RO[2]=1, RO[0]=0 after.
- Timeout: word0=10, no done → acc_abort_o in 10th RUN cycle, RO[1]=10, RO[3]=0x0001_0001, RO[2] unchanged.
- Tie: word0=4, done in 4th RUN cycle → no abort, RO[2]+=1, RO[3] unchanged.
- Backpressure: valid held with new set while busy → not accepted until IDLE; acc_cfg_o stays at old set during job, then takes new set.
- Clear-stats: after 3 jobs and 1 abort, accept set with word6=0x8000_0000 → RO[2]=0, RO[3]=0 at accept, job runs, RO[2]=1 after done.
